// File: rtl/div32_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div32_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned    DIV_W         = 32;
  localparam logic [4:0]     DIV_ITER_LAST = 5'd31;
  localparam logic [31:0]    DZ_QUOTIENT   = 32'hFFFF_FFFF;

  // Two's-complement negation; 0x8000_0000 maps onto itself, which is what
  // both the magnitude conversion and the overflow result rely on.
  function automatic logic [DIV_W-1:0] neg_w(input logic [DIV_W-1:0] v);
    logic signed [DIV_W-1:0] s;
    s = v;
    return DIV_W'(-s);
  endfunction

endpackage

// File: rtl/div32_seq_sub33.sv
// 33-bit subtractor a - b as a + ~b + 1, with borrow = ~carry_out.
module sub33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  output logic [32:0] diff,
  output logic        borrow
);
  logic carry;

  assign {carry, diff} = {1'b0, a} + {1'b0, ~b} + 34'd1;
  assign borrow        = ~carry;

endmodule

// File: rtl/div32_seq.sv
// Sequential 32-bit restoring divider, one quotient bit per cycle.
// Signed mode is compiled in only when DIV_SIGNED_EN is defined.
module div32_seq
  import div32_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_start,
  input  logic             op_clear,
  input  logic             i_signed,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             dz,
  output logic             ov
);

  state_t           state;
  logic [4:0]       count;
  logic [DIV_W-1:0] rem_acc, quo_acc, dvsr;
  logic [DIV_W-1:0] rem_nxt, quo_nxt;
  logic [DIV_W:0]   diff;
  logic             borrow;
  logic             neg_q, neg_r, ov_pend;
  logic             accept;

  logic [DIV_W-1:0] dvd_mag, dvs_mag;
  logic             sgn_q, sgn_r, ov_det;
  logic             unused_diff_msb;

  assign unused_diff_msb = diff[DIV_W];

  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
    sgn_q   = 1'b0;
    sgn_r   = 1'b0;
    ov_det  = 1'b0;
`ifdef DIV_SIGNED_EN
    if (i_signed) begin
      dvd_mag = dividend[DIV_W-1] ? neg_w(dividend) : dividend;
      dvs_mag = divisor[DIV_W-1]  ? neg_w(divisor)  : divisor;
      sgn_q   = dividend[DIV_W-1] ^ divisor[DIV_W-1];
      sgn_r   = dividend[DIV_W-1];
      ov_det  = (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
    end
`endif
  end

`ifndef DIV_SIGNED_EN
  logic unused_sgn;
  assign unused_sgn = i_signed;
`endif

  sub33 u_sub33 (
    .a      ({rem_acc, quo_acc[DIV_W-1]}),
    .b      ({1'b0, dvsr}),
    .diff   (diff),
    .borrow (borrow)
  );

  // One restoring step: keep R on borrow, otherwise take the difference.
  assign rem_nxt = borrow ? {rem_acc[DIV_W-2:0], quo_acc[DIV_W-1]} : diff[DIV_W-1:0];
  assign quo_nxt = {quo_acc[DIV_W-2:0], ~borrow};
  assign accept  = op_start && !op_clear && (state == IDLE || state == DONE);

  // Datapath stage: iteration registers, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_acc <= '0;
      quo_acc <= dvd_mag;
      dvsr    <= dvs_mag;
    end else if (state == BUSY) begin
      rem_acc <= rem_nxt;
      quo_acc <= quo_nxt;
    end
  end

  // Control stage: FSM and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      dz        <= 1'b0;
      ov        <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      ov_pend   <= 1'b0;
    end else if (op_clear) begin
      state     <= IDLE;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      dz        <= 1'b0;
      ov        <= 1'b0;
      ov_pend   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (op_start) begin
            count   <= '0;
            ov      <= 1'b0;
            neg_q   <= sgn_q;
            neg_r   <= sgn_r;
            ov_pend <= ov_det;
            if (divisor == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              dz        <= 1'b1;
              quotient  <= DZ_QUOTIENT;
              remainder <= dividend;
            end else begin
              state <= BUSY;
              done  <= 1'b0;
              busy  <= 1'b1;
              dz    <= 1'b0;
            end
          end
        end
        BUSY: begin
          count <= count + 5'd1;
          if (count == DIV_ITER_LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            ov        <= ov_pend;
            quotient  <= neg_q ? neg_w(quo_nxt) : quo_nxt;
            remainder <= neg_r ? neg_w(rem_nxt) : rem_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Directed bench for div32_seq; signed vectors are exercised when DIV_SIGNED_EN is defined.
module tb_div32_seq;

  logic        clk;
  logic        reset_n;
  logic        op_start;
  logic        op_clear;
  logic        i_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;
  logic        busy;
  logic        dz;
  logic        ov;

  int total = 0;
  int bad   = 0;
  int lat, bcnt;
  logic done0;

  div32_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op_start  (op_start),
    .op_clear  (op_clear),
    .i_signed  (i_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .busy      (busy),
    .dz        (dz),
    .ov        (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one operation; lat counts edges after the capture edge until done,
  // bcnt counts samples with busy high, d0 is done right after the capture edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat_o, output int bcnt_o, output logic d0);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    i_signed = s;
    op_start = 1'b1;
    @(posedge clk);
    #1;
    op_start = 1'b0;
    d0     = done;
    lat_o  = 0;
    bcnt_o = busy ? 1 : 0;
    while (!done && lat_o < 40) begin
      @(posedge clk);
      #1;
      lat_o++;
      if (busy) bcnt_o++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_q"},    quotient,  32'h0);
    check({tag, "_r"},    remainder, 32'h0);
    check({tag, "_done"}, done,      32'h0);
    check({tag, "_busy"}, busy,      32'h0);
    check({tag, "_dz"},   dz,        32'h0);
    check({tag, "_ov"},   ov,        32'h0);
  endtask

  initial begin
    reset_n  = 1'b0;
    op_start = 1'b0;
    op_clear = 1'b0;
    i_signed = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    @(negedge clk);
    reset_n = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, lat, bcnt, done0);
    check("u100_7_lat",  32'(lat),  32'd32);
    check("u100_7_busy", 32'(bcnt), 32'd32);
    check("u100_7_q",    quotient,  32'd14);
    check("u100_7_r",    remainder, 32'd2);
    check("u100_7_dz",   dz,        32'd0);
    check("u100_7_bz",   busy,      32'd0);

    // Held stable in DONE
    repeat (3) @(posedge clk);
    #1;
    check("hold_done", done,     32'd1);
    check("hold_q",    quotient, 32'd14);

    run_op(32'd5, 32'd0, 1'b0, lat, bcnt, done0);
    check("dz_lat",  32'(lat <= 1), 32'd1);
    check("dz_busy", 32'(bcnt),     32'd0);
    check("dz_done", done,          32'd1);
    check("dz_flag", dz,            32'd1);
    check("dz_q",    quotient,      32'hFFFF_FFFF);
    check("dz_r",    remainder,     32'd5);

    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat, bcnt, done0);
    check("max_1_lat", 32'(lat),  32'd32);
    check("max_1_dz",  dz,        32'd0);
    check("max_1_q",   quotient,  32'hFFFF_FFFF);
    check("max_1_r",   remainder, 32'd0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bcnt, done0);
    check("b2b_done_drop", done0,     32'd0);
    check("b2b_lat",       32'(lat),  32'd32);
    check("b2b_q",         quotient,  32'd1);
    check("b2b_r",         remainder, 32'd0);

    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bcnt, done0);
    check("u_min_m1_q",  quotient,  32'd0);
    check("u_min_m1_r",  remainder, 32'h8000_0000);
    check("u_min_m1_ov", ov,        32'd0);

`ifdef DIV_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat, bcnt, done0);
    check("s_m7_2_q",  quotient,  32'hFFFF_FFFD);
    check("s_m7_2_r",  remainder, 32'hFFFF_FFFF);
    check("s_m7_2_ov", ov,        32'd0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, lat, bcnt, done0);
    check("s_7_m2_q", quotient,  32'hFFFF_FFFD);
    check("s_7_m2_r", remainder, 32'd1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bcnt, done0);
    check("s_ov_lat", 32'(lat),  32'd32);
    check("s_ov_flag", ov,       32'd1);
    check("s_ov_q",   quotient,  32'h8000_0000);
    check("s_ov_r",   remainder, 32'd0);
`else
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat, bcnt, done0);
    check("nos_q",  quotient,  32'h7FFF_FFFC);
    check("nos_r",  remainder, 32'd1);
    check("nos_ov", ov,        32'd0);
`endif

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    i_signed = 1'b0;
    op_start = 1'b1;
    @(posedge clk);
    #1;
    op_start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("arst");
    @(negedge clk);
    reset_n = 1'b1;
    run_op(32'd100, 32'd7, 1'b0, lat, bcnt, done0);
    check("post_rst_lat", 32'(lat),  32'd32);
    check("post_rst_q",   quotient,  32'd14);
    check("post_rst_r",   remainder, 32'd2);

    // Clear wins over start in DONE
    @(negedge clk);
    dividend = 32'd9;
    divisor  = 32'd3;
    op_start = 1'b1;
    op_clear = 1'b1;
    @(posedge clk);
    #1;
    op_start = 1'b0;
    op_clear = 1'b0;
    check_zero("clr");
    repeat (2) @(posedge clk);
    #1;
    check("clr_idle_busy", busy, 32'd0);
    check("clr_idle_done", done, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
